if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; directly upstream of the decode stage.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Holds one fetched instruction in a single-entry buffer and presents it, with PC+4 and trace tags, to decode.
- Honours load-stall (cu_wpcir) and branch/jump redirect (cu_branch, ID_new_pc) from decode.

---
 rtl/if_stage.sv | 155 +++++++++++++++
 tb/tb_if_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage with PC, single-entry instruction buffer and req/ack imem port; IF_FETCH_COUNT_EN adds fetch_count.
// Latency: instruction presented the cycle after imem_ack; a redirect target appears 2 cycles after cu_branch.
// Backpressure: cu_wpcir holds the buffer and suppresses new requests while it is full.
module if_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [3:0]  INST_TYPE_NONE = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_wpcir,
  input  logic        cu_branch,
  input  logic [31:0] ID_new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        drop_q, drop_d;
  logic        buf_vld_q, buf_vld_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [3:0]  buf_seq_q, buf_seq_d;
  logic [3:0]  seq_q, seq_d;

  logic        consume;
  logic        fire;
  logic [31:0] target;

  assign consume   = buf_vld_q & ~cu_wpcir & ~cu_branch;
  // Gated by rst so the request is low while reset is held.
  assign imem_req  = rst & (drop_q | ~buf_vld_q | consume);
  assign imem_addr = pc_q;
  assign fire      = imem_req & imem_ack;
  assign target    = ID_new_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    drop_d     = drop_q;
    buf_vld_d  = buf_vld_q;
    buf_inst_d = buf_inst_q;
    buf_pc4_d  = buf_pc4_q;
    buf_seq_d  = buf_seq_q;
    seq_d      = seq_q;
    case (state_q)
      FETCH: begin
        if (consume) buf_vld_d = 1'b0;
        if (cu_branch) begin
          buf_vld_d = 1'b0;
          // An unacked request must complete at its old address before the jump.
          if (imem_req && !imem_ack) begin
            state_d = DRAIN;
            drop_d  = 1'b1;
            tgt_d   = target;
          end else begin
            pc_d = target;
          end
        end else if (fire) begin
          buf_vld_d  = 1'b1;
          buf_inst_d = imem_rdata;
          buf_pc4_d  = pc_q + 32'd4;
          buf_seq_d  = seq_q;
          seq_d      = seq_q + 4'd1;
          pc_d       = pc_q + 32'd4;
        end
      end
      DRAIN: begin
        if (cu_branch) tgt_d = target;
        if (fire) begin
          pc_d    = cu_branch ? target : tgt_q;
          drop_d  = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      tgt_q      <= RESET_PC;
      drop_q     <= 1'b0;
      buf_vld_q  <= 1'b0;
      buf_inst_q <= 32'd0;
      buf_pc4_q  <= 32'd0;
      buf_seq_q  <= 4'd0;
      seq_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      drop_q     <= drop_d;
      buf_vld_q  <= buf_vld_d;
      buf_inst_q <= buf_inst_d;
      buf_pc4_q  <= buf_pc4_d;
      buf_seq_q  <= buf_seq_d;
      seq_q      <= seq_d;
    end
  end

  assign if_valid      = buf_vld_q;
  assign if_inst       = buf_vld_q ? buf_inst_q : 32'd0;
  assign if_pc4        = buf_vld_q ? buf_pc4_q : 32'd0;
  assign IF_ins_number = buf_seq_q;

  always_comb begin
    IF_ins_type = INST_TYPE_NONE;
    if (buf_vld_q) begin
      casez (buf_inst_q[31:26])
        6'b000000: IF_ins_type = 4'd1;
        6'b001???: IF_ins_type = 4'd2;
        6'b100011: IF_ins_type = 4'd3;
        6'b101011: IF_ins_type = 4'd4;
        6'b00010?: IF_ins_type = 4'd5;
        6'b00001?: IF_ins_type = 4'd6;
        default:   IF_ins_type = 4'd7;
      endcase
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (consume && fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_count_q <= 32'd0;
    else      fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: imem model returns addr-as-data except a few fixed opcode words,
// with a programmable number of wait cycles before ack.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        cu_wpcir;
  logic        cu_branch;
  logic [31:0] ID_new_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic [3:0]  IF_ins_type;
  logic [3:0]  IF_ins_number;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat  = 0;
  int wait_cnt = 0;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .cu_wpcir     (cu_wpcir),
    .cu_branch    (cu_branch),
    .ID_new_pc    (ID_new_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_inst      (if_inst),
    .if_pc4       (if_pc4),
    .if_valid     (if_valid),
    .IF_ins_type  (IF_ins_type),
    .IF_ins_number(IF_ins_number)
`ifdef IF_FETCH_COUNT_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model
  assign imem_ack = imem_req && (wait_cnt >= mem_lat);

  always_comb begin
    imem_rdata = imem_addr;
    case (imem_addr)
      32'h10: imem_rdata = 32'h8C22_0004;
      32'h40: imem_rdata = 32'h2001_0005;
      32'h44: imem_rdata = 32'hAC22_0000;
      32'h48: imem_rdata = 32'h1000_FFFF;
      32'h4C: imem_rdata = 32'h0800_0000;
      32'h50: imem_rdata = 32'hFC00_0000;
      default: imem_rdata = imem_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] inst, input logic [31:0] pc4,
                           input logic vld, input logic [3:0] typ, input logic [3:0] num);
    check({tag, ".inst"}, if_inst, inst);
    check({tag, ".pc4"}, if_pc4, pc4);
    check({tag, ".valid"}, if_valid, vld);
    check({tag, ".type"}, IF_ins_type, typ);
    check({tag, ".num"}, IF_ins_number, num);
  endtask

  initial begin
    rst       = 1'b0;
    cu_wpcir  = 1'b0;
    cu_branch = 1'b0;
    ID_new_pc = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.req", imem_req, 1'b0);
    check("rst.addr", imem_addr, 32'h0);
    check_out("rst", 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);

    // Zero-wait streaming from reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel.req", imem_req, 1'b1);
    check("rel.addr", imem_addr, 32'h0);
    tick;
    check_out("s0", 32'h0, 32'h4, 1'b1, 4'd1, 4'd0);
    check("s0.addr", imem_addr, 32'h4);
    tick;
    check_out("s1", 32'h4, 32'h8, 1'b1, 4'd1, 4'd1);
    check("s1.addr", imem_addr, 32'h8);
    tick;
    check_out("s2", 32'h8, 32'hC, 1'b1, 4'd1, 4'd2);
    check("s2.addr", imem_addr, 32'hC);
    tick;
    tick;
    check_out("lw", 32'h8C22_0004, 32'h14, 1'b1, 4'd3, 4'd4);

    // Load stall for two cycles
    cu_wpcir = 1'b1;
    #1;
    check("stall.req", imem_req, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick;
      check_out("stall", 32'h8C22_0004, 32'h14, 1'b1, 4'd3, 4'd4);
      check("stall.addr", imem_addr, 32'h14);
    end
    cu_wpcir = 1'b0;
    #1;
    check("unstall.req", imem_req, 1'b1);
    tick;
    check_out("resume", 32'h14, 32'h18, 1'b1, 4'd1, 4'd5);

    // Redirect with zero-wait memory; low target bits must be ignored
    cu_branch = 1'b1;
    ID_new_pc = 32'h0000_0043;
    #1;
    check("br.req", imem_req, 1'b0);
    tick;
    cu_branch = 1'b0;
    #1;
    check_out("br.bubble", 32'h0, 32'h0, 1'b0, 4'd0, 4'd5);
    check("br.addr", imem_addr, 32'h40);
    tick;
    check_out("br.tgt", 32'h2001_0005, 32'h44, 1'b1, 4'd2, 4'd6);
    tick;
    check_out("sw", 32'hAC22_0000, 32'h48, 1'b1, 4'd4, 4'd7);
    tick;
    check_out("beq", 32'h1000_FFFF, 32'h4C, 1'b1, 4'd5, 4'd8);
    tick;
    check_out("j", 32'h0800_0000, 32'h50, 1'b1, 4'd6, 4'd9);
    tick;
    check_out("other", 32'hFC00_0000, 32'h54, 1'b1, 4'd7, 4'd10);

    // Slow memory: redirect in a wait cycle drains the old request first
    mem_lat = 3;
    #1;
    check("slow.req", imem_req, 1'b1);
    tick;
    cu_branch = 1'b1;
    ID_new_pc = 32'h0000_0100;
    #1;
    check("slow.addr0", imem_addr, 32'h54);
    check("slow.valid0", if_valid, 1'b0);
    tick;
    cu_branch = 1'b0;
    #1;
    check("drain.req1", imem_req, 1'b1);
    check("drain.addr1", imem_addr, 32'h54);
    check("drain.valid1", if_valid, 1'b0);
    tick;
    check("drain.ack", imem_ack, 1'b1);
    check("drain.addr2", imem_addr, 32'h54);
    check("drain.valid2", if_valid, 1'b0);
    tick;
    check_out("drain.done", 32'h0, 32'h0, 1'b0, 4'd0, 4'd10);
    check("drain.newaddr", imem_addr, 32'h100);
    check("drain.newreq", imem_req, 1'b1);
    mem_lat = 0;
    tick;
    check_out("drain.tgt", 32'h100, 32'h104, 1'b1, 4'd1, 4'd11);

    // Reset asserted in the middle of DRAIN
    mem_lat = 3;
    tick;
    cu_branch = 1'b1;
    ID_new_pc = 32'h0000_0200;
    tick;
    cu_branch = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("mrst.req", imem_req, 1'b0);
    check_out("mrst", 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    mem_lat = 0;
    rst = 1'b1;
    #1;
    check("mrst.addr", imem_addr, 32'h0);
    check("mrst.relreq", imem_req, 1'b1);
    tick;
    check_out("mrst.first", 32'h0, 32'h4, 1'b1, 4'd1, 4'd0);

`ifdef IF_FETCH_COUNT_EN
    // 10 consumed, 1 stalled, 1 redirected and 1 discarded fetch
    check("fc.zero", fetch_count, 32'd0);
    cu_wpcir = 1'b1;
    tick;
    cu_wpcir = 1'b0;
    repeat (10) tick;
    check("fc.ten", fetch_count, 32'd10);
    check("fc.buf", if_inst, 32'h28);
    cu_branch = 1'b1;
    ID_new_pc = 32'h0000_0080;
    tick;
    tick;
    cu_branch = 1'b0;
    tick;
    check("fc.redir", fetch_count, 32'd10);
    check("fc.tgt", if_inst, 32'h80);
    tick;
    check("fc.eleven", fetch_count, 32'd11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
